// File: rtl/hub75_phy_div.sv
// HUB75 panel PHY with divided shift clock.
// Streams one SDW-wide column word per CLK_DIV system cycles onto hub75_data,
// generates hub75_clk inside each bit period, pulses hub75_le on request and
// registers the row address / blanking controls.
// Optional build macro: HUB75_PHY_BLANK_GUARD_EN (blank forced during latch,
// address outputs only move while the panel is blanked).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting; data word wins over latch request, hub75_clk held 1
// SHIFT   | presenting one word for CLK_DIV cycles, cnt = cycle in period
// LATCH   | hub75_le high for LE_LEN cycles, no handshakes accepted

module hub75_phy_div #(
   parameter int N_BANKS   = 2,
   parameter int N_ROWS    = 32,
   parameter int N_CHANS   = 3,
   parameter int PHY_N     = 1,
   parameter int PHY_AIR   = 0,
   parameter int CLK_DIV   = 4,
   parameter int CLK_PHASE = 2,
   parameter int LE_LEN    = 2,
   localparam int SDW        = N_BANKS * N_CHANS,
   localparam int LOG_N_ROWS = $clog2(N_ROWS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [SDW-1:0]              phy_data,
   input  logic                        phy_data_valid,
   output logic                        phy_data_ready,
   input  logic                        phy_le_valid,
   output logic                        phy_le_ready,
   input  logic [LOG_N_ROWS-1:0]       phy_addr,
   input  logic                        phy_addr_inc,
   input  logic                        phy_addr_rst,
   input  logic                        phy_blank,
   output logic [SDW-1:0]              hub75_data,
   output logic [PHY_N-1:0]            hub75_clk,
   output logic [PHY_N-1:0]            hub75_le,
   output logic [PHY_N-1:0]            hub75_blank,
   output logic [PHY_N-1:0]            hub75_addr_inc,
   output logic [PHY_N-1:0]            hub75_addr_rst,
   output logic [PHY_N*LOG_N_ROWS-1:0] hub75_addr
);

   localparam int CW = 5;
   localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PHASE  = CW'(CLK_PHASE);
   localparam logic [CW-1:0] LE_M1  = CW'(LE_LEN - 1);
   localparam logic INC_INV = 1'((PHY_AIR >> 1) & 1);
   localparam logic RST_INV = 1'((PHY_AIR >> 2) & 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_inc;
   logic            rdy_en;
   logic            data_acc;
   logic            le_acc;
   logic            blank_next;
   logic            addr_upd;

   // rdy_en holds both ready outputs low until one full clock after reset release
   assign phy_data_ready = rdy_en & ((state == ST_IDLE) ||
                                     ((state == ST_SHIFT) && (cnt == DIV_M1)));
   assign phy_le_ready   = rdy_en & (state == ST_IDLE) & ~phy_data_valid;
   assign data_acc       = phy_data_valid & phy_data_ready;
   assign le_acc         = phy_le_valid & phy_le_ready;
   assign cnt_inc        = cnt + 1'b1;

`ifdef HUB75_PHY_BLANK_GUARD_EN
   // Entering latch, during latch and the cycle after it the panel stays blanked.
   assign blank_next = phy_blank | (state == ST_LATCH) | le_acc;
   assign addr_upd   = hub75_blank[0];
`else
   assign blank_next = phy_blank;
   assign addr_upd   = 1'b1;
`endif

   // Sequencer: shift-word divider, latch pulse and registered clk/le/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         rdy_en     <= 1'b0;
         hub75_data <= '0;
         hub75_clk  <= '1;
         hub75_le   <= '0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (data_acc) begin
                  state      <= ST_SHIFT;
                  cnt        <= '0;
                  hub75_data <= phy_data;
                  hub75_clk  <= '0;
               end else if (le_acc) begin
                  state    <= ST_LATCH;
                  cnt      <= '0;
                  hub75_le <= '1;
               end
            end
            ST_SHIFT: begin
               if (cnt == DIV_M1) begin
                  cnt <= '0;
                  if (data_acc) begin
                     hub75_data <= phy_data;
                     hub75_clk  <= '0;
                  end else begin
                     state     <= ST_IDLE;
                     hub75_clk <= '1;
                  end
               end else begin
                  cnt       <= cnt_inc;
                  hub75_clk <= {PHY_N{cnt_inc >= PHASE}};
               end
            end
            ST_LATCH: begin
               if (cnt == LE_M1) begin
                  state    <= ST_IDLE;
                  cnt      <= '0;
                  hub75_le <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               hub75_clk <= '1;
               hub75_le  <= '0;
            end
         endcase
      end
   end

   // Blanking is a plain one-cycle register of the (possibly guarded) request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hub75_blank <= '1;
      else        hub75_blank <= {PHY_N{blank_next}};
   end

   generate
      if (PHY_AIR == 0) begin : g_bin
         logic unused_air;
         assign unused_air     = &{1'b0, phy_addr_inc, phy_addr_rst};
         assign hub75_addr_inc = '0;
         assign hub75_addr_rst = '0;

         // Binary row address replicated to every panel port.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        hub75_addr <= '0;
            else if (addr_upd) hub75_addr <= {PHY_N{phy_addr}};
         end
      end else begin : g_air
         logic unused_addr;
         assign unused_addr = &{1'b0, phy_addr};
         assign hub75_addr  = '0;

         // Increment/reset row drive with per-signal polarity inversion.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hub75_addr_inc <= {PHY_N{INC_INV}};
               hub75_addr_rst <= {PHY_N{RST_INV}};
            end else if (addr_upd) begin
               hub75_addr_inc <= {PHY_N{phy_addr_inc ^ INC_INV}};
               hub75_addr_rst <= {PHY_N{phy_addr_rst ^ RST_INV}};
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_hub75_phy_div.sv
// Bench for hub75_phy_div: default instance plus an inc/rst (PHY_AIR=6) instance
// sharing the same stimulus. Expected per-cycle outputs are queued as stimulus
// is driven and compared one entry per clock at the falling edge.

module tb_hub75_phy_div;

`ifdef HUB75_PHY_BLANK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [5:0] phy_data;
   logic       phy_data_valid;
   logic       phy_le_valid;
   logic [4:0] phy_addr;
   logic       phy_addr_inc;
   logic       phy_addr_rst;
   logic       phy_blank;

   logic       phy_data_ready, phy_le_ready;
   logic [5:0] hub75_data;
   logic       hub75_clk, hub75_le, hub75_blank, hub75_addr_inc, hub75_addr_rst;
   logic [4:0] hub75_addr;

   logic       a_data_ready, a_le_ready;
   logic [5:0] a_data;
   logic       a_clk, a_le, a_blank, a_addr_inc, a_addr_rst;
   logic [4:0] a_addr;

   hub75_phy_div dut (
      .clk(clk), .rst_n(rst_n),
      .phy_data(phy_data), .phy_data_valid(phy_data_valid), .phy_data_ready(phy_data_ready),
      .phy_le_valid(phy_le_valid), .phy_le_ready(phy_le_ready),
      .phy_addr(phy_addr), .phy_addr_inc(phy_addr_inc), .phy_addr_rst(phy_addr_rst),
      .phy_blank(phy_blank),
      .hub75_data(hub75_data), .hub75_clk(hub75_clk), .hub75_le(hub75_le),
      .hub75_blank(hub75_blank), .hub75_addr_inc(hub75_addr_inc),
      .hub75_addr_rst(hub75_addr_rst), .hub75_addr(hub75_addr)
   );

   hub75_phy_div #(.PHY_AIR(6)) dut_air (
      .clk(clk), .rst_n(rst_n),
      .phy_data(phy_data), .phy_data_valid(phy_data_valid), .phy_data_ready(a_data_ready),
      .phy_le_valid(phy_le_valid), .phy_le_ready(a_le_ready),
      .phy_addr(phy_addr), .phy_addr_inc(phy_addr_inc), .phy_addr_rst(phy_addr_rst),
      .phy_blank(phy_blank),
      .hub75_data(a_data), .hub75_clk(a_clk), .hub75_le(a_le),
      .hub75_blank(a_blank), .hub75_addr_inc(a_addr_inc),
      .hub75_addr_rst(a_addr_rst), .hub75_addr(a_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] data;
      logic       hclk;
      logic       le;
      logic       drdy;
      logic       lrdy;
      logic       blank;
      logic [4:0] addr;
      logic       ainc;
      logic       arst;
   } exp_t;

   exp_t  sb_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";
   int    cyc_no  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s cycle %0d: got %0h expected %0h", phase, tag, cyc_no, act, exp);
      end
   endtask

   // Queue the expectation for the coming clock, advance, then compare it.
   task automatic step(input logic [5:0] d, input logic hc, input logic le,
                       input logic dr, input logic lr, input logic bl,
                       input logic [4:0] ad, input logic ai, input logic ar);
      exp_t e;
      e.data = d; e.hclk = hc; e.le = le; e.drdy = dr; e.lrdy = lr;
      e.blank = bl; e.addr = ad; e.ainc = ai; e.arst = ar;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      cyc_no++;
      e = sb_q.pop_front();
      check_eq("data",   32'(hub75_data),     32'(e.data));
      check_eq("hclk",   32'(hub75_clk),      32'(e.hclk));
      check_eq("le",     32'(hub75_le),       32'(e.le));
      check_eq("drdy",   32'(phy_data_ready), 32'(e.drdy));
      check_eq("lrdy",   32'(phy_le_ready),   32'(e.lrdy));
      check_eq("blank",  32'(hub75_blank),    32'(e.blank));
      check_eq("addr",   32'(hub75_addr),     32'(e.addr));
      check_eq("ainc",   32'(a_addr_inc),     32'(e.ainc));
      check_eq("arst",   32'(a_addr_rst),     32'(e.arst));
   endtask

   initial begin
      logic       gb;
      logic [4:0] ga;
      rst_n = 1'b0;
      phy_data = '0; phy_data_valid = 1'b0; phy_le_valid = 1'b0;
      phy_addr = '0; phy_addr_inc = 1'b0; phy_addr_rst = 1'b0; phy_blank = 1'b0;

      phase = "reset";
      step(6'h00, 1, 0, 0, 0, 1, 5'd0, 1, 1);
      step(6'h00, 1, 0, 0, 0, 1, 5'd0, 1, 1);
      check_eq("bin_inc", 32'(hub75_addr_inc), 32'd0);
      check_eq("air_addr", 32'(a_addr), 32'd0);

      // Word offered at release: must not be taken on the first edge.
      phase = "b2b";
      rst_n = 1'b1; phy_blank = 1'b1; phy_data = 6'h15; phy_data_valid = 1'b1;
      #1 check_eq("rdy_post_rst", 32'(phy_data_ready), 32'd0);
      step(6'h00, 1, 0, 1, 0, 1, 5'd0, 1, 1);
      step(6'h15, 0, 0, 0, 0, 1, 5'd0, 1, 1);
      phy_data = 6'h2A;
      step(6'h15, 0, 0, 0, 0, 1, 5'd0, 1, 1);
      step(6'h15, 1, 0, 0, 0, 1, 5'd0, 1, 1);
      step(6'h15, 1, 0, 1, 0, 1, 5'd0, 1, 1);
      step(6'h2A, 0, 0, 0, 0, 1, 5'd0, 1, 1);
      phy_data_valid = 1'b0;
      step(6'h2A, 0, 0, 0, 0, 1, 5'd0, 1, 1);
      step(6'h2A, 1, 0, 0, 0, 1, 5'd0, 1, 1);
      step(6'h2A, 1, 0, 1, 0, 1, 5'd0, 1, 1);
      step(6'h2A, 1, 0, 1, 1, 1, 5'd0, 1, 1);

      // Data and latch requested together: word first, then LE_LEN le pulse.
      phase = "prio";
      phy_blank = 1'b0; phy_data = 6'h0C; phy_data_valid = 1'b1; phy_le_valid = 1'b1;
      step(6'h0C, 0, 0, 0, 0, 0, 5'd0, 1, 1);
      phy_data_valid = 1'b0;
      step(6'h0C, 0, 0, 0, 0, 0, 5'd0, 1, 1);
      step(6'h0C, 1, 0, 0, 0, 0, 5'd0, 1, 1);
      step(6'h0C, 1, 0, 1, 0, 0, 5'd0, 1, 1);
      step(6'h0C, 1, 0, 1, 1, 0, 5'd0, 1, 1);
      step(6'h0C, 1, 1, 0, 0, GUARD, 5'd0, 1, 1);
      phy_le_valid = 1'b0;
      step(6'h0C, 1, 1, 0, 0, GUARD, 5'd0, 1, 1);
      step(6'h0C, 1, 0, 1, 1, GUARD, 5'd0, 1, 1);
      step(6'h0C, 1, 0, 1, 1, 0, 5'd0, 1, 1);

      // Row address vs blanking; guarded build holds address while unblanked.
      phase = "addr";
      phy_blank = 1'b1; phy_addr = 5'd3;
      ga = GUARD ? 5'd0 : 5'd3;
      step(6'h0C, 1, 0, 1, 1, 1, ga, 1, 1);
      step(6'h0C, 1, 0, 1, 1, 1, 5'd3, 1, 1);
      phy_blank = 1'b0;
      step(6'h0C, 1, 0, 1, 1, 0, 5'd3, 1, 1);
      phy_addr = 5'd5;
      ga = GUARD ? 5'd3 : 5'd5;
      step(6'h0C, 1, 0, 1, 1, 0, ga, 1, 1);
      step(6'h0C, 1, 0, 1, 1, 0, ga, 1, 1);
      phy_blank = 1'b1;
      step(6'h0C, 1, 0, 1, 1, 1, ga, 1, 1);
      step(6'h0C, 1, 0, 1, 1, 1, 5'd5, 1, 1);

      // Inverted inc/rst pulses on the PHY_AIR=6 instance.
      phase = "air";
      phy_addr_inc = 1'b1;
      step(6'h0C, 1, 0, 1, 1, 1, 5'd5, 0, 1);
      phy_addr_inc = 1'b0; phy_addr_rst = 1'b1;
      step(6'h0C, 1, 0, 1, 1, 1, 5'd5, 1, 0);
      phy_addr_rst = 1'b0;
      step(6'h0C, 1, 0, 1, 1, 1, 5'd5, 1, 1);
      check_eq("air_addr2", 32'(a_addr), 32'd0);

      // Reset asserted at cnt=1 of a shift aborts cleanly.
      phase = "rst_mid";
      phy_data = 6'h33; phy_data_valid = 1'b1;
      step(6'h33, 0, 0, 0, 0, 1, 5'd5, 1, 1);
      phy_data_valid = 1'b0;
      step(6'h33, 0, 0, 0, 0, 1, 5'd5, 1, 1);
      rst_n = 1'b0;
      step(6'h00, 1, 0, 0, 0, 1, 5'd0, 1, 1);
      rst_n = 1'b1;
      gb = 1'b1;
      step(6'h00, 1, 0, 1, 1, gb, 5'd5, 1, 1);
      for (int i = 0; i < 3; i++) step(6'h00, 1, 0, 1, 1, gb, 5'd5, 1, 1);
      phy_data = 6'h0A; phy_data_valid = 1'b1;
      step(6'h0A, 0, 0, 0, 0, 1, 5'd5, 1, 1);
      phy_data_valid = 1'b0;
      step(6'h0A, 0, 0, 0, 0, 1, 5'd5, 1, 1);
      step(6'h0A, 1, 0, 0, 0, 1, 5'd5, 1, 1);
      step(6'h0A, 1, 0, 1, 0, 1, 5'd5, 1, 1);
      step(6'h0A, 1, 0, 1, 1, 1, 5'd5, 1, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time limit so the bench always ends.
   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
